// File: rtl/rnd_range_sampler_pkg.sv
// Shared game definitions for the random-range sampler: word width, FSM states
// and the rejection-sampling mask generator.
package rnd_range_sampler_pkg;

    localparam int unsigned RND_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        DONE
    } state_e;

    // Smear the most significant 1 downwards so every bit at or below it is set.
    function automatic logic [RND_W-1:0] mask_for(input logic [RND_W-1:0] x);
        logic [RND_W-1:0] m;
        m = x;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        return m;
    endfunction

endpackage

// File: rtl/rnd_range_sampler_if.sv
// Request/result handshake bundle between gameplay logic (master) and the
// random-range sampler (slave).
interface rnd_range_sampler_if;
    import rnd_range_sampler_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [RND_W-1:0] req_limit;
    logic             out_valid;
    logic             out_ready;
    logic [RND_W-1:0] out_value;
    logic             out_err;
    logic [3:0]       out_tries;

    modport master (
        output req_valid, req_limit, out_ready,
        input  req_ready, out_valid, out_value, out_err, out_tries
    );

    modport slave (
        input  req_valid, req_limit, out_ready,
        output req_ready, out_valid, out_value, out_err, out_tries
    );

endinterface

// File: rtl/rnd_range_sampler.sv
// Returns a uniform value in [0, limit) from a free-running random stream using
// masked rejection sampling with a bounded-retry fallback.
module rnd_range_sampler
    import rnd_range_sampler_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RND_W-1:0]      rnd,
    rnd_range_sampler_if.slave    bus
);

    state_e           state_q, state_d;
    logic [RND_W-1:0] limit_q, limit_d;
    logic [RND_W-1:0] mask_q,  mask_d;
    logic [RND_W-1:0] value_q, value_d;
    logic             err_q,   err_d;
    logic [3:0]       tries_q, tries_d;

    logic [RND_W-1:0] cand;
    logic [3:0]       tries_n;
    logic             req_ready;
    logic             out_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            limit_q <= '0;
            mask_q  <= '0;
            value_q <= '0;
            err_q   <= 1'b0;
            tries_q <= '0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            mask_q  <= mask_d;
            value_q <= value_d;
            err_q   <= err_d;
            tries_q <= tries_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        mask_d    = mask_q;
        value_d   = value_q;
        err_d     = err_q;
        tries_d   = tries_q;
        req_ready = 1'b0;
        out_valid = 1'b0;
        cand      = rnd & mask_q;
        tries_n   = tries_q + 4'd1;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    limit_d = bus.req_limit;
                    mask_d  = mask_for(bus.req_limit - 1'b1);
                    tries_d = '0;
                    if (bus.req_limit == '0) begin
                        value_d = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                tries_d = tries_n;
                if (cand < limit_q) begin
                    value_d = cand;
                    state_d = DONE;
                end else if (tries_n == 4'(MAX_TRIES + 1)) begin
                    // mask <= 2*limit-1, so one subtraction lands inside the range
                    value_d = cand - limit_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_value = value_q;
    assign bus.out_err   = err_q;
    assign bus.out_tries = tries_q;

endmodule
